commit_unit: RTL and testbench

Consumer end of the ROB commit interface. Each cycle it takes up to `COMMIT_WIDTH` in-order retiring ROB entries and applies their architectural effects:
- releases old physical registers to the free list;
- updates the architectural RAT;
- sends the single BPU training update;
- turns exceptions, interrupts, `ertn`, mispredicts and serialising instructions into one registered pipeline flush plus a redirect PC.

It sits between the ReorderBuffer commit port and the rename, frontend and CSR blocks. Its `flush_o` drives the ROB's `flush_i`.

---
 rtl/commit_unit_pkg.sv | 104 ++++++++++
 rtl/commit_unit_flush_ctrl.sv | 138 +++++++++++++
 rtl/commit_unit.sv | 136 +++++++++++++
 tb/tb_commit_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_unit_pkg.sv
// Shared types and constants for the commit unit (ROB commit consumer).
package commit_unit_pkg;

    localparam int unsigned COMMIT_WIDTH = 2;
    localparam int unsigned PHY_REG_NUM  = 64;
    localparam int unsigned PW           = $clog2(PHY_REG_NUM);
    localparam int unsigned AREG_W       = 5;
    localparam int unsigned ECODE_W      = 6;
    localparam int unsigned SUBCODE_W    = 9;
    localparam int unsigned BR_TYPE_W    = 2;
    localparam int unsigned BR_INFO_W    = 8;

    localparam logic [ECODE_W-1:0] ECODE_INT  = 6'h00;
    localparam logic [ECODE_W-1:0] ECODE_ADEF = 6'h08;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        FLUSH     = 2'd1,
        IDLE_WAIT = 2'd2
    } CmtStateEn;

    typedef enum logic [1:0] {
        ALU_INSTR = 2'd0,
        BR_INSTR  = 2'd1,
        MEM_INSTR = 2'd2,
        CSR_INSTR = 2'd3
    } InstrTypeEn;

    typedef struct packed {
        logic                 valid;
        logic [ECODE_W-1:0]   ecode;
        logic [SUBCODE_W-1:0] subcode;
    } RobExcpSt;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          instr;
        InstrTypeEn           instr_type;
        RobExcpSt             excp;
        logic [31:0]          error_vaddr;
        logic                 old_phy_reg_valid;
        logic [PW-1:0]        old_phy_reg;
        logic [AREG_W-1:0]    areg;
        logic [PW-1:0]        phy_reg;
        logic                 br_taken;
        logic [31:0]          br_target;
        logic [BR_TYPE_W-1:0] br_type;
        logic [BR_INFO_W-1:0] br_info;
        logic                 br_redirect;
        logic                 ertn_flush;
        logic                 priv_flush;
        logic                 ibar_flush;
        logic                 icacop_flush;
        logic                 idle_flush;
        logic                 rf_wen;
        logic [31:0]          rf_wdata;
        logic                 store_valid;
        logic                 load_valid;
        logic [31:0]          paddr;
        logic [31:0]          vaddr;
        logic [31:0]          csr_rdata;
    } RobEntrySt;

    typedef struct packed {
        logic [COMMIT_WIDTH-1:0]        valid;
        RobEntrySt [COMMIT_WIDTH-1:0]   rob_entry;
    } RobCmtSt;

    typedef struct packed {
        logic                 valid;
        logic [31:0]          pc;
        logic                 br_taken;
        logic [31:0]          br_target;
        logic [BR_TYPE_W-1:0] br_type;
        logic [BR_INFO_W-1:0] br_info;
    } CmtBpuUpdSt;

    typedef struct packed {
        logic                 valid;
        logic [ECODE_W-1:0]   ecode;
        logic [SUBCODE_W-1:0] subcode;
        logic [31:0]          era;
        logic [31:0]          badv;
    } CmtExcpSt;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rf_wen;
        logic [31:0] rf_wdata;
        logic        store_valid;
        logic        load_valid;
        logic [31:0] paddr;
        logic [31:0] vaddr;
        logic [31:0] csr_rdata;
    } CmtDifftestSt;

    // Sequential next-pc; wraps at 2^32.
    function automatic logic [31:0] pc_add4(input logic [31:0] pc);
        return 32'(pc + 32'd4);
    endfunction

endpackage

// File: rtl/commit_unit_flush_ctrl.sv
// Commit FSM: cause priority, effective/retire mask and registered flush/redirect/excp.
module commit_flush_ctrl
    import commit_unit_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  RobCmtSt                 cmt_i,
    input  logic                    has_int,
    input  logic [31:0]             eentry_i,
    input  logic [31:0]             era_i,
    output logic [COMMIT_WIDTH-1:0] retire_c,
    output logic                    flush_o,
    output logic                    redirect_o,
    output logic [31:0]             redirect_pc_o,
    output CmtExcpSt                excp_o,
    output logic                    ertn_o
);

    CmtStateEn   state_q, state_d;
    logic [31:0] idle_pc_q, idle_pc_d;
    logic        flush_d;
    logic        redirect_d;
    logic [31:0] redirect_pc_d;
    CmtExcpSt    excp_d;
    logic        ertn_d;
    logic        blocked;

    // Only control fields of the entries are consumed here; the rest feed the datapath.
    logic unused_cmt_bits;
    assign unused_cmt_bits = ^cmt_i;

    // Next state, retire mask and flush payload; oldest slot with a cause wins.
    always_comb begin
        state_d       = state_q;
        idle_pc_d     = idle_pc_q;
        retire_c      = '0;
        flush_d       = 1'b0;
        redirect_d    = 1'b0;
        redirect_pc_d = '0;
        excp_d        = '0;
        ertn_d        = 1'b0;
        blocked       = 1'b0;
        case (state_q)
            RUN: begin
                for (int i = 0; i < COMMIT_WIDTH; i++) begin
                    if (cmt_i.valid[i] && !blocked) begin
                        if ((i == 0) && has_int) begin
                            blocked       = 1'b1;
                            flush_d       = 1'b1;
                            redirect_d    = 1'b1;
                            redirect_pc_d = eentry_i;
                            excp_d.valid  = 1'b1;
                            excp_d.ecode  = ECODE_INT;
                            excp_d.era    = cmt_i.rob_entry[i].pc;
                            state_d       = FLUSH;
                        end else if (cmt_i.rob_entry[i].excp.valid) begin
                            blocked        = 1'b1;
                            flush_d        = 1'b1;
                            redirect_d     = 1'b1;
                            redirect_pc_d  = eentry_i;
                            excp_d.valid   = 1'b1;
                            excp_d.ecode   = cmt_i.rob_entry[i].excp.ecode;
                            excp_d.subcode = cmt_i.rob_entry[i].excp.subcode;
                            excp_d.era     = cmt_i.rob_entry[i].pc;
                            excp_d.badv    = cmt_i.rob_entry[i].error_vaddr;
                            state_d        = FLUSH;
                        end else begin
                            retire_c[i] = 1'b1;
                            if (cmt_i.rob_entry[i].ertn_flush) begin
                                blocked       = 1'b1;
                                flush_d       = 1'b1;
                                redirect_d    = 1'b1;
                                redirect_pc_d = era_i;
                                ertn_d        = 1'b1;
                                state_d       = FLUSH;
                            end else if (cmt_i.rob_entry[i].br_redirect) begin
                                blocked       = 1'b1;
                                flush_d       = 1'b1;
                                redirect_d    = 1'b1;
                                redirect_pc_d = cmt_i.rob_entry[i].br_target;
                                state_d       = FLUSH;
                            end else if (cmt_i.rob_entry[i].priv_flush ||
                                         cmt_i.rob_entry[i].ibar_flush ||
                                         cmt_i.rob_entry[i].icacop_flush) begin
                                blocked       = 1'b1;
                                flush_d       = 1'b1;
                                redirect_d    = 1'b1;
                                redirect_pc_d = pc_add4(cmt_i.rob_entry[i].pc);
                                state_d       = FLUSH;
                            end else if (cmt_i.rob_entry[i].idle_flush) begin
                                blocked   = 1'b1;
                                idle_pc_d = cmt_i.rob_entry[i].pc;
                                state_d   = IDLE_WAIT;
                            end
                        end
                    end
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            IDLE_WAIT: begin
                // Wake goes through FLUSH so younger entries are discarded, not committed.
                if (has_int) begin
                    flush_d       = 1'b1;
                    redirect_d    = 1'b1;
                    redirect_pc_d = pc_add4(idle_pc_q);
                    state_d       = FLUSH;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State, stored idle pc and registered flush outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            idle_pc_q     <= '0;
            flush_o       <= 1'b0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
            excp_o        <= '0;
            ertn_o        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idle_pc_q     <= idle_pc_d;
            flush_o       <= flush_d;
            redirect_o    <= redirect_d;
            redirect_pc_o <= redirect_pc_d;
            excp_o        <= excp_d;
            ertn_o        <= ertn_d;
        end
    end

endmodule

// File: rtl/commit_unit.sv
// Commit unit top: retires ROB entries into free list, arch RAT and BPU; flush via commit_flush_ctrl.
// Optional feature macro: COMMIT_DIFFTEST_EN adds difftest_o and a 64-bit retired-instruction counter.
module commit_unit
    import commit_unit_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  RobCmtSt                        cmt_i,
    input  logic                           has_int,
    input  logic [31:0]                    eentry_i,
    input  logic [31:0]                    era_i,
    output logic [COMMIT_WIDTH-1:0]        free_valid_o,
    output logic [COMMIT_WIDTH*PW-1:0]     free_preg_o,
    output logic [COMMIT_WIDTH-1:0]        arat_we_o,
    output logic [COMMIT_WIDTH*AREG_W-1:0] arat_areg_o,
    output logic [COMMIT_WIDTH*PW-1:0]     arat_preg_o,
    output CmtBpuUpdSt                     bpu_upd_o,
    output logic                           flush_o,
    output logic                           redirect_o,
    output logic [31:0]                    redirect_pc_o,
    output CmtExcpSt                       excp_o,
    output logic                           ertn_o
`ifdef COMMIT_DIFFTEST_EN
    ,
    output CmtDifftestSt [COMMIT_WIDTH-1:0] difftest_o,
    output logic [63:0]                     instr_cnt_o
`endif
);

    logic [COMMIT_WIDTH-1:0]        retire_c;
    logic [COMMIT_WIDTH-1:0]        free_valid_d;
    logic [COMMIT_WIDTH*PW-1:0]     free_preg_d;
    logic [COMMIT_WIDTH-1:0]        arat_we_d;
    logic [COMMIT_WIDTH*AREG_W-1:0] arat_areg_d;
    logic [COMMIT_WIDTH*PW-1:0]     arat_preg_d;
    CmtBpuUpdSt                     bpu_d;
    logic                           bpu_found;

    commit_flush_ctrl u_flush_ctrl (
        .clk           (clk),
        .rst           (rst),
        .cmt_i         (cmt_i),
        .has_int       (has_int),
        .eentry_i      (eentry_i),
        .era_i         (era_i),
        .retire_c      (retire_c),
        .flush_o       (flush_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .excp_o        (excp_o),
        .ertn_o        (ertn_o)
    );

    // RAT/free-list writes for retired slots; BPU update from the oldest retired branch.
    always_comb begin
        free_valid_d = '0;
        free_preg_d  = '0;
        arat_we_d    = '0;
        arat_areg_d  = '0;
        arat_preg_d  = '0;
        bpu_d        = '0;
        bpu_found    = 1'b0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (retire_c[i] && cmt_i.rob_entry[i].old_phy_reg_valid) begin
                free_valid_d[i]                = 1'b1;
                free_preg_d[i*PW +: PW]        = cmt_i.rob_entry[i].old_phy_reg;
                arat_we_d[i]                   = 1'b1;
                arat_areg_d[i*AREG_W +: AREG_W] = cmt_i.rob_entry[i].areg;
                arat_preg_d[i*PW +: PW]        = cmt_i.rob_entry[i].phy_reg;
            end
            if (retire_c[i] && !bpu_found && (cmt_i.rob_entry[i].instr_type == BR_INSTR)) begin
                bpu_found       = 1'b1;
                bpu_d.valid     = 1'b1;
                bpu_d.pc        = cmt_i.rob_entry[i].pc;
                bpu_d.br_taken  = cmt_i.rob_entry[i].br_taken;
                bpu_d.br_target = cmt_i.rob_entry[i].br_target;
                bpu_d.br_type   = cmt_i.rob_entry[i].br_type;
                bpu_d.br_info   = cmt_i.rob_entry[i].br_info;
            end
        end
    end

    // Register the retire datapath outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_valid_o <= '0;
            free_preg_o  <= '0;
            arat_we_o    <= '0;
            arat_areg_o  <= '0;
            arat_preg_o  <= '0;
            bpu_upd_o    <= '0;
        end else begin
            free_valid_o <= free_valid_d;
            free_preg_o  <= free_preg_d;
            arat_we_o    <= arat_we_d;
            arat_areg_o  <= arat_areg_d;
            arat_preg_o  <= arat_preg_d;
            bpu_upd_o    <= bpu_d;
        end
    end

`ifdef COMMIT_DIFFTEST_EN
    CmtDifftestSt [COMMIT_WIDTH-1:0] difftest_d;

    // Per-slot trace record of normally retired instructions.
    always_comb begin
        difftest_d = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (retire_c[i]) begin
                difftest_d[i].valid       = 1'b1;
                difftest_d[i].pc          = cmt_i.rob_entry[i].pc;
                difftest_d[i].instr       = cmt_i.rob_entry[i].instr;
                difftest_d[i].rf_wen      = cmt_i.rob_entry[i].rf_wen;
                difftest_d[i].rf_wdata    = cmt_i.rob_entry[i].rf_wdata;
                difftest_d[i].store_valid = cmt_i.rob_entry[i].store_valid;
                difftest_d[i].load_valid  = cmt_i.rob_entry[i].load_valid;
                difftest_d[i].paddr       = cmt_i.rob_entry[i].paddr;
                difftest_d[i].vaddr       = cmt_i.rob_entry[i].vaddr;
                difftest_d[i].csr_rdata   = cmt_i.rob_entry[i].csr_rdata;
            end
        end
    end

    // Trace register and retired-instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            difftest_o  <= '0;
            instr_cnt_o <= '0;
        end else begin
            difftest_o  <= difftest_d;
            instr_cnt_o <= instr_cnt_o + 64'($countones(retire_c));
        end
    end
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Directed self-checking bench for commit_unit.
module tb_commit_unit;
    import commit_unit_pkg::*;

    logic                           clk;
    logic                           rst;
    RobCmtSt                        cmt;
    logic                           has_int;
    logic [31:0]                    eentry;
    logic [31:0]                    era;
    logic [COMMIT_WIDTH-1:0]        free_valid;
    logic [COMMIT_WIDTH*PW-1:0]     free_preg;
    logic [COMMIT_WIDTH-1:0]        arat_we;
    logic [COMMIT_WIDTH*AREG_W-1:0] arat_areg;
    logic [COMMIT_WIDTH*PW-1:0]     arat_preg;
    CmtBpuUpdSt                     bpu_upd;
    logic                           flush;
    logic                           redirect;
    logic [31:0]                    redirect_pc;
    CmtExcpSt                       excp;
    logic                           ertn;

    int checks = 0;
    int errors = 0;

    commit_unit dut (
        .clk           (clk),
        .rst           (rst),
        .cmt_i         (cmt),
        .has_int       (has_int),
        .eentry_i      (eentry),
        .era_i         (era),
        .free_valid_o  (free_valid),
        .free_preg_o   (free_preg),
        .arat_we_o     (arat_we),
        .arat_areg_o   (arat_areg),
        .arat_preg_o   (arat_preg),
        .bpu_upd_o     (bpu_upd),
        .flush_o       (flush),
        .redirect_o    (redirect),
        .redirect_pc_o (redirect_pc),
        .excp_o        (excp),
        .ertn_o        (ertn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic RobEntrySt mk(input logic [31:0] pc, input InstrTypeEn t,
                                     input logic ov, input logic [PW-1:0] opr,
                                     input logic [AREG_W-1:0] areg, input logic [PW-1:0] preg);
        RobEntrySt e;
        e = '0;
        e.pc                = pc;
        e.instr_type        = t;
        e.old_phy_reg_valid = ov;
        e.old_phy_reg       = opr;
        e.areg              = areg;
        e.phy_reg           = preg;
        return e;
    endfunction

    initial begin
        rst     = 1'b1;
        cmt     = '0;
        has_int = 1'b0;
        eentry  = 32'h1c00_8000;
        era     = 32'h1c00_0300;

        // Reset values
        #12;
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_free_valid", 64'(free_valid), 64'd0);
        chk("rst_excp_valid", 64'(excp.valid), 64'd0);
        chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
        chk("rst_bpu_valid", 64'(bpu_upd.valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Two normal ALU slots
        cmt.valid        = 2'b11;
        cmt.rob_entry[0] = mk(32'h1c00_0000, ALU_INSTR, 1'b1, 6'd12, 5'd4, 6'd20);
        cmt.rob_entry[1] = mk(32'h1c00_0004, ALU_INSTR, 1'b1, 6'd13, 5'd5, 6'd21);
        step();
        chk("alu_free_valid", 64'(free_valid), 64'b11);
        chk("alu_free_preg", 64'(free_preg), 64'({6'd13, 6'd12}));
        chk("alu_arat_we", 64'(arat_we), 64'b11);
        chk("alu_arat_areg", 64'(arat_areg), 64'({5'd5, 5'd4}));
        chk("alu_arat_preg", 64'(arat_preg), 64'({6'd21, 6'd20}));
        chk("alu_flush", 64'(flush), 64'd0);
        chk("alu_bpu_valid", 64'(bpu_upd.valid), 64'd0);

        // Asynchronous reset clears outputs before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("arst_free_valid", 64'(free_valid), 64'd0);
        chk("arst_arat_we", 64'(arat_we), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cmt = '0;
        step();
        chk("idle_free_valid", 64'(free_valid), 64'd0);

        // Slot 0 mispredicted branch, slot 1 dropped
        cmt.valid        = 2'b11;
        cmt.rob_entry[0] = mk(32'h1c00_0010, BR_INSTR, 1'b1, 6'd7, 5'd1, 6'd30);
        cmt.rob_entry[0].br_redirect = 1'b1;
        cmt.rob_entry[0].br_taken    = 1'b1;
        cmt.rob_entry[0].br_target   = 32'h1c00_0100;
        cmt.rob_entry[1] = mk(32'h1c00_0014, ALU_INSTR, 1'b1, 6'd14, 5'd6, 6'd31);
        step();
        chk("br_free_valid", 64'(free_valid), 64'b01);
        chk("br_free_preg", 64'(free_preg), 64'({6'd0, 6'd7}));
        chk("br_bpu_valid", 64'(bpu_upd.valid), 64'd1);
        chk("br_bpu_pc", 64'(bpu_upd.pc), 64'h1c00_0010);
        chk("br_bpu_target", 64'(bpu_upd.br_target), 64'h1c00_0100);
        chk("br_bpu_taken", 64'(bpu_upd.br_taken), 64'd1);
        chk("br_flush", 64'(flush), 64'd1);
        chk("br_redirect", 64'(redirect), 64'd1);
        chk("br_redirect_pc", 64'(redirect_pc), 64'h1c00_0100);
        step();
        chk("br_flush_pulse_end", 64'(flush), 64'd0);
        chk("br_flush_cycle_ignores_cmt", 64'(free_valid), 64'd0);
        chk("br_redirect_end", 64'(redirect), 64'd0);
        cmt = '0;
        step();

        // Exception in slot 0
        cmt.valid        = 2'b11;
        cmt.rob_entry[0] = mk(32'h1c00_0020, ALU_INSTR, 1'b1, 6'd9, 5'd2, 6'd33);
        cmt.rob_entry[0].excp.valid  = 1'b1;
        cmt.rob_entry[0].excp.ecode  = ECODE_ADEF;
        cmt.rob_entry[0].error_vaddr = 32'h1c00_0021;
        cmt.rob_entry[1] = mk(32'h1c00_0024, ALU_INSTR, 1'b1, 6'd10, 5'd3, 6'd34);
        step();
        chk("exc_free_valid", 64'(free_valid), 64'd0);
        chk("exc_arat_we", 64'(arat_we), 64'd0);
        chk("exc_valid", 64'(excp.valid), 64'd1);
        chk("exc_ecode", 64'(excp.ecode), 64'(ECODE_ADEF));
        chk("exc_era", 64'(excp.era), 64'h1c00_0020);
        chk("exc_badv", 64'(excp.badv), 64'h1c00_0021);
        chk("exc_flush", 64'(flush), 64'd1);
        chk("exc_redirect_pc", 64'(redirect_pc), 64'h1c00_8000);
        cmt = '0;
        step();
        chk("exc_valid_end", 64'(excp.valid), 64'd0);

        // Interrupt on slot 0
        has_int          = 1'b1;
        cmt.valid        = 2'b01;
        cmt.rob_entry[0] = mk(32'h1c00_0040, ALU_INSTR, 1'b1, 6'd11, 5'd7, 6'd35);
        step();
        chk("int_free_valid", 64'(free_valid), 64'd0);
        chk("int_excp_valid", 64'(excp.valid), 64'd1);
        chk("int_ecode", 64'(excp.ecode), 64'(ECODE_INT));
        chk("int_era", 64'(excp.era), 64'h1c00_0040);
        chk("int_flush", 64'(flush), 64'd1);
        chk("int_redirect_pc", 64'(redirect_pc), 64'h1c00_8000);
        has_int = 1'b0;
        cmt     = '0;
        step();

        // ertn in slot 1, slot 0 retires
        cmt.valid        = 2'b11;
        cmt.rob_entry[0] = mk(32'h1c00_0050, ALU_INSTR, 1'b1, 6'd3, 5'd8, 6'd36);
        cmt.rob_entry[1] = mk(32'h1c00_0054, CSR_INSTR, 1'b0, 6'd0, 5'd0, 6'd0);
        cmt.rob_entry[1].ertn_flush = 1'b1;
        step();
        chk("ertn_free_valid", 64'(free_valid), 64'b01);
        chk("ertn_o", 64'(ertn), 64'd1);
        chk("ertn_flush", 64'(flush), 64'd1);
        chk("ertn_redirect_pc", 64'(redirect_pc), 64'h1c00_0300);
        chk("ertn_excp_valid", 64'(excp.valid), 64'd0);
        cmt = '0;
        step();

        // priv flush at top of address space wraps to 0
        cmt.valid        = 2'b01;
        cmt.rob_entry[0] = mk(32'hffff_fffc, CSR_INSTR, 1'b1, 6'd5, 5'd9, 6'd37);
        cmt.rob_entry[0].priv_flush = 1'b1;
        step();
        chk("priv_free_valid", 64'(free_valid), 64'b01);
        chk("priv_flush", 64'(flush), 64'd1);
        chk("priv_redirect_pc_wrap", 64'(redirect_pc), 64'h0000_0000);
        cmt = '0;
        step();

        // Two branches retire; only the oldest trains the BPU
        cmt.valid        = 2'b11;
        cmt.rob_entry[0] = mk(32'h1c00_0060, BR_INSTR, 1'b0, 6'd0, 5'd0, 6'd0);
        cmt.rob_entry[1] = mk(32'h1c00_0064, BR_INSTR, 1'b0, 6'd0, 5'd0, 6'd0);
        cmt.rob_entry[1].br_target = 32'h1c00_0abc;
        step();
        chk("bpu2_valid", 64'(bpu_upd.valid), 64'd1);
        chk("bpu2_pc", 64'(bpu_upd.pc), 64'h1c00_0060);
        chk("bpu2_flush", 64'(flush), 64'd0);
        cmt = '0;
        step();

        // idle, then interrupt 10 cycles later
        cmt.valid        = 2'b11;
        cmt.rob_entry[0] = mk(32'h1c00_0200, CSR_INSTR, 1'b0, 6'd0, 5'd0, 6'd0);
        cmt.rob_entry[0].idle_flush = 1'b1;
        cmt.rob_entry[1] = mk(32'h1c00_0204, ALU_INSTR, 1'b1, 6'd15, 5'd10, 6'd38);
        step();
        chk("idle_flush", 64'(flush), 64'd0);
        chk("idle_slot1_dropped", 64'(free_valid), 64'd0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("idle_wait_flush", 64'(flush), 64'd0);
            chk("idle_wait_free_valid", 64'(free_valid), 64'd0);
        end
        has_int = 1'b1;
        step();
        chk("wake_flush", 64'(flush), 64'd1);
        chk("wake_redirect", 64'(redirect), 64'd1);
        chk("wake_redirect_pc", 64'(redirect_pc), 64'h1c00_0204);
        chk("wake_excp_valid", 64'(excp.valid), 64'd0);
        cmt.valid        = 2'b01;
        cmt.rob_entry[0] = mk(32'h1c00_0204, ALU_INSTR, 1'b1, 6'd15, 5'd10, 6'd38);
        cmt.rob_entry[1] = '0;
        step();
        chk("wake_pulse_end", 64'(flush), 64'd0);
        chk("wake_flush_cycle_free", 64'(free_valid), 64'd0);
        step();
        chk("wake_int_valid", 64'(excp.valid), 64'd1);
        chk("wake_int_ecode", 64'(excp.ecode), 64'(ECODE_INT));
        chk("wake_int_era", 64'(excp.era), 64'h1c00_0204);
        chk("wake_int_flush", 64'(flush), 64'd1);
        has_int = 1'b0;
        cmt     = '0;
        step();

        // Reset during IDLE_WAIT aborts the pending wake flush
        cmt.valid        = 2'b01;
        cmt.rob_entry[0] = mk(32'h1c00_0400, CSR_INSTR, 1'b0, 6'd0, 5'd0, 6'd0);
        cmt.rob_entry[0].idle_flush = 1'b1;
        step();
        cmt = '0;
        step();
        #2 rst = 1'b1;
        #1;
        chk("idle_rst_flush", 64'(flush), 64'd0);
        chk("idle_rst_redirect_pc", 64'(redirect_pc), 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        has_int = 1'b1;
        step();
        chk("post_rst_no_flush", 64'(flush), 64'd0);
        chk("post_rst_no_redirect", 64'(redirect), 64'd0);
        has_int = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
